// File: rtl/riscv_result_monitor.sv
// riscv_result_monitor
// End-of-test detector that snoops the data-memory write port of riscv_top.
// It counts RUN cycles and writes, keeps the last written address/data, and
// latches a sticky pass/fail/timeout verdict together with the IF/ID PC seen
// on the verdict edge. All outputs come straight from registers.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// S_IDLE    | disarmed, counters held at 0, writes ignored
// S_RUN     | counting cycles, classifying each dmem write
// S_PASS    | pass address written with pass data (terminal)
// S_FAIL    | write to any address other than scratch/pass-ok (terminal)
// S_TIMEOUT | cycle budget exhausted with no verdict write (terminal)
module riscv_result_monitor #(
  parameter int P_DATA_WIDTH      = 32,
  parameter int P_DMEM_ADDR_WIDTH = 8,
  parameter int P_PASS_ADDR       = 100,
  parameter int P_PASS_DATA       = 25,
  parameter int P_SCRATCH_ADDR    = 96,
  parameter int P_TIMEOUT_CYCLES  = 5000,
  parameter int P_CNT_WIDTH       = 32
) (
  input  logic                         i_clk,
  input  logic                         i_rst_n,
  input  logic                         i_en,
  input  logic                         i_clear,
  input  logic                         i_dmem_we,
  input  logic [P_DMEM_ADDR_WIDTH-1:0] i_dmem_addr,
  input  logic [P_DATA_WIDTH-1:0]      i_dmem_wdata,
  input  logic [P_DATA_WIDTH-1:0]      i_if_pc,
  output logic                         o_done,
  output logic                         o_pass,
  output logic                         o_fail,
  output logic                         o_timeout,
  output logic [P_CNT_WIDTH-1:0]       o_cycle_count,
  output logic [15:0]                  o_write_count,
  output logic [P_DMEM_ADDR_WIDTH-1:0] o_last_addr,
  output logic [P_DATA_WIDTH-1:0]      o_last_data,
  output logic [P_DATA_WIDTH-1:0]      o_last_pc
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RUN,
    S_PASS,
    S_FAIL,
    S_TIMEOUT
  } state_t;

  // Parameters are compared at port width, so truncate them once here.
  localparam logic [P_DMEM_ADDR_WIDTH-1:0] PASS_ADDR    = P_DMEM_ADDR_WIDTH'(P_PASS_ADDR);
  localparam logic [P_DMEM_ADDR_WIDTH-1:0] SCRATCH_ADDR = P_DMEM_ADDR_WIDTH'(P_SCRATCH_ADDR);
  localparam logic [P_DATA_WIDTH-1:0]      PASS_DATA    = P_DATA_WIDTH'(P_PASS_DATA);
  localparam logic [P_CNT_WIDTH-1:0]       TIMEOUT_LAST = P_CNT_WIDTH'(P_TIMEOUT_CYCLES - 1);

  state_t                         state_q, state_d;
  logic [P_CNT_WIDTH-1:0]         cycle_q, cycle_d;
  logic [15:0]                    write_q, write_d;
  logic [P_DMEM_ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [P_DATA_WIDTH-1:0]        data_q, data_d;
  logic [P_DATA_WIDTH-1:0]        pc_q, pc_d;

  // State and capture registers; reset clears everything asynchronously.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= S_IDLE;
      cycle_q <= '0;
      write_q <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      pc_q    <= '0;
    end else begin
      state_q <= state_d;
      cycle_q <= cycle_d;
      write_q <= write_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      pc_q    <= pc_d;
    end
  end

  // Next-state: clear dominates; RUN counts, classifies writes, then checks timeout.
  always_comb begin
    state_d = state_q;
    cycle_d = cycle_q;
    write_d = write_q;
    addr_d  = addr_q;
    data_d  = data_q;
    pc_d    = pc_q;
    if (i_clear) begin
      state_d = S_IDLE;
      cycle_d = '0;
      write_d = '0;
      addr_d  = '0;
      data_d  = '0;
      pc_d    = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (i_en) state_d = S_RUN;
        end
        S_RUN: begin
          if (cycle_q != '1) cycle_d = cycle_q + P_CNT_WIDTH'(1);
          if (i_dmem_we) begin
            if (write_q != 16'hFFFF) write_d = write_q + 16'd1;
            addr_d = i_dmem_addr;
            data_d = i_dmem_wdata;
            if (i_dmem_addr == PASS_ADDR && i_dmem_wdata == PASS_DATA) begin
              state_d = S_PASS;
            end else if (i_dmem_addr != SCRATCH_ADDR) begin
              state_d = S_FAIL;
            end
          end
          // A write verdict on the same edge takes precedence over timeout.
          if (state_d == S_RUN && cycle_q == TIMEOUT_LAST) state_d = S_TIMEOUT;
          if (state_d != S_RUN) pc_d = i_if_pc;
        end
        default: ;
      endcase
    end
  end

  // Verdict flags are decoded from the state register only.
  always_comb begin
    o_pass    = (state_q == S_PASS);
    o_fail    = (state_q == S_FAIL);
    o_timeout = (state_q == S_TIMEOUT);
    o_done    = o_pass | o_fail | o_timeout;
  end

  assign o_cycle_count = cycle_q;
  assign o_write_count = write_q;
  assign o_last_addr   = addr_q;
  assign o_last_data   = data_q;
  assign o_last_pc     = pc_q;

endmodule

// File: doc/riscv_result_monitor.md
# riscv_result_monitor

Synthesizable end-of-test detector on the data-memory write port of `riscv_top`. It snoops the core's dmem write strobe, address and data, counts run cycles, and issues a sticky pass/fail/timeout verdict. The same completion check can then run on FPGA or in any bench without hierarchical probing. It sits beside the data memory, consuming the same `dmem_we`/`dmem_addr`/`dmem_wdata` signals the memory receives, plus the IF/ID PC for post-mortem capture.

## Interface
- P_DATA_WIDTH, 32, dmem write-data and PC width
- P_DMEM_ADDR_WIDTH, 8, dmem address width
- P_PASS_ADDR, 100, address whose write with P_PASS_DATA ends the test successfully
- P_PASS_DATA, 25, expected data at P_PASS_ADDR
- P_SCRATCH_ADDR, 96, only address that may be written without ending the test
- P_TIMEOUT_CYCLES, 5000, RUN cycles allowed before timeout (≥2)
- P_CNT_WIDTH, 32, cycle counter width
- i_clk  in  1  clock, rising edge
- i_rst_n  in  1  asynchronous active-low reset
- i_en  in  1  arm; IDLE→RUN when high
- i_clear  in  1  synchronous clear to IDLE, highest synchronous priority
- i_dmem_we  in  1  dmem write strobe
- i_dmem_addr  in  P_DMEM_ADDR_WIDTH  dmem address
- i_dmem_wdata  in  P_DATA_WIDTH  dmem write data
- i_if_pc  in  P_DATA_WIDTH  IF/ID-stage PC
- o_done  out  1  o_pass | o_fail | o_timeout
- o_pass, o_fail, o_timeout  out  1 each  one-hot sticky verdict
- o_cycle_count  out  P_CNT_WIDTH  RUN cycles elapsed
- o_write_count  out  16  dmem writes observed in RUN
- o_last_addr  out  P_DMEM_ADDR_WIDTH  address of the most recent write
- o_last_data  out  P_DATA_WIDTH  data of the most recent write
- o_last_pc  out  P_DATA_WIDTH  i_if_pc captured on the verdict edge

## Operation
- States: IDLE, RUN, PASS, FAIL, TIMEOUT. All registers are state-owned; outputs decode directly from registers.
- Reset (async, i_rst_n=0): state IDLE; every output 0.
- IDLE: counters hold 0. When i_en=1, go to RUN on the next edge. Writes in IDLE are ignored.
- RUN, each edge:
  - o_cycle_count += 1, saturating at all-ones.
  - When i_dmem_we=1:
    - o_write_count += 1, saturating at 0xFFFF.
    - Capture o_last_addr and o_last_data.
    - Classify the write:
      - addr==P_PASS_ADDR and data==P_PASS_DATA → PASS.
      - Otherwise, addr!=P_SCRATCH_ADDR → FAIL. This includes the pass address written with wrong data.
      - addr==P_SCRATCH_ADDR → stay in RUN.
  - With no verdict write, if o_cycle_count==P_TIMEOUT_CYCLES-1 → TIMEOUT.
  - A write verdict in the same edge as timeout wins: PASS/FAIL beats TIMEOUT.
  - On any transition out of RUN, capture o_last_pc from i_if_pc.
- i_en dropping during RUN has no effect; it is only an arm signal.
- PASS/FAIL/TIMEOUT are terminal. Counters, captures and the verdict freeze. Further writes are ignored.
- i_clear=1 at any state → IDLE, all outputs 0 on that edge, regardless of a simultaneous write or timeout.
- Comparisons are exact equality on the full port widths. Parameters are truncated to the port width.

## Timing
- All outputs are registered. The verdict asserts on the edge that samples the deciding write, so it is visible in the following cycle. Latency from write presented to o_done is 1 cycle.
- IDLE→RUN takes 1 edge. A write presented in the Nth RUN cycle yields o_cycle_count==N.
- Timeout: o_timeout=1 and o_cycle_count==P_TIMEOUT_CYCLES after exactly P_TIMEOUT_CYCLES RUN cycles.
- Reset mid-RUN clears all outputs immediately, without waiting for a clock edge. After release, the first edge with i_en=1 re-arms.
- Combinational paths input→output: none.

## Test plan
- Reset/idle: hold i_rst_n=0 for 3 cycles, release with i_en=0 for 10 cycles, and drive a write to addr 100, data 25 → all outputs stay 0, o_done=0.
- Pass:
  - Stimulus: i_en=1; write (96, 7) in RUN cycle 3; write (100, 25) in RUN cycle 10.
  - Required response, one cycle later: o_pass=1, o_done=1, o_cycle_count=10, o_write_count=2, o_last_addr=100, o_last_data=25, and o_last_pc equals i_if_pc driven in cycle 10.
- Fail:
  - Write (104, 25) → o_fail=1, o_pass=0.
  - Separate run: write (100, 24) → o_fail=1.
  - Separate run: write (96, x) repeatedly for 50 cycles → stays RUN, o_write_count=50.
- Timeout with P_TIMEOUT_CYCLES=20:
  - No writes → o_timeout=1 after 20 RUN cycles, o_cycle_count=20.
  - Rerun with write (100, 25) in RUN cycle 20 → o_pass=1, o_timeout=0.
- Sticky/clear:
  - After PASS, write (104, 1) → outputs unchanged.
  - i_clear pulse coincident with a write → all outputs 0, state IDLE.
  - i_en=1 re-arms, and count restarts from 1.
- Async reset mid-run: assert i_rst_n=0 at 37% of a clock period while in RUN with o_cycle_count=15 → all outputs 0 before the next rising edge.
